// File: rtl/proc_tx_handshake_pkg.sv
// Shared types and sizing helpers for the processor-side send/ack transmitter.
package proc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        BACKOFF = 2'd3
    } hs_state_t;

    // Index width for a FIFO of the given depth; the pointers carry one extra wrap bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/proc_tx_handshake_if.sv
// Processor write port plus peripheral send/ack handshake, bundled for the transmitter.
interface proc_tx_handshake_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              ack;
    logic              send;
    logic [DATA_W-1:0] dado;
    logic              busy;
    logic              timeout_err;
    logic [CNT_W-1:0]  sent_count;

    modport master (
        output wr_en, wr_data, ack,
        input  full, send, dado, busy, timeout_err, sent_count
    );

    modport slave (
        input  wr_en, wr_data, ack,
        output full, send, dado, busy, timeout_err, sent_count
    );
endinterface

// File: rtl/proc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push and pop may land on the same edge.
module proc_sync_fifo
    import proc_hs_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wptr;
    logic [PTR_W:0]    rptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign head  = mem[rptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/proc_tx_handshake.sv
// Queues processor words and drains them over a 4-phase send/ack handshake with timeout and retry.
module proc_tx_handshake
    import proc_hs_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input logic                clk,
    input logic                rst,
    proc_tx_handshake_if.slave bus
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] R_MAX  = RTY_W'(MAX_RETRY);

    hs_state_t         state;
    logic [TMR_W-1:0]  timer;
    logic [RTY_W-1:0]  retry;
    logic              send_q;
    logic [DATA_W-1:0] dado_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] head;
    logic              empty;
    logic              full;
    logic              expired;
    logic              pop;

    assign expired = (timer == T_LAST);
    // The head leaves the FIFO only once it is delivered or given up on.
    assign pop = (state == REQ) && (bus.ack || (expired && retry >= R_MAX));

    proc_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.wr_data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            timer  <= '0;
            retry  <= '0;
            send_q <= 1'b0;
            dado_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        dado_q <= head;
                        send_q <= 1'b1;
                        timer  <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the expiry edge still counts as a delivery.
                    if (bus.ack) begin
                        send_q <= 1'b0;
                        cnt_q  <= cnt_q + 1'b1;
                        retry  <= '0;
                        state  <= RELEASE;
                    end else if (expired && retry < R_MAX) begin
                        send_q <= 1'b0;
                        retry  <= retry + 1'b1;
                        state  <= BACKOFF;
                    end else if (expired) begin
                        send_q <= 1'b0;
                        err_q  <= 1'b1;
                        retry  <= '0;
                        state  <= RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!bus.ack) state <= IDLE;
                end
                BACKOFF: begin
                    send_q <= 1'b1;
                    timer  <= '0;
                    state  <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full        = full;
    assign bus.send        = send_q;
    assign bus.dado        = dado_q;
    assign bus.busy        = (state != IDLE) || !empty;
    assign bus.timeout_err = err_q;
    assign bus.sent_count  = cnt_q;

endmodule

// File: tb/tb_proc_tx_handshake.sv
// Table-driven and scoreboard-checked bench for the send/ack transmitter.
module tb_proc_tx_handshake;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 15;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 2;
    localparam int NEVER     = 99;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                drop;
    } sb_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                attempt;
        int                delay;
        bit                drop;
        int                windows;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    proc_tx_handshake_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    proc_tx_handshake #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sb_t  exp_q[$];
    int   run_q[$];
    int   gap_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_attempt = NEVER;
    int   ack_delay = 0;
    bit   manual = 1'b0;
    logic man_ack = 1'b0;
    logic resp_ack = 1'b0;
    int   attempt = 0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    int   model_cnt = 0;
    logic s_send = 1'b0;
    logic s_ack = 1'b0;
    logic s_err = 1'b0;

    assign bus.ack = manual ? man_ack : resp_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic word_event(input bit dropped);
        sb_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: word completed (drop=%0d) with nothing expected", dropped);
        end else begin
            e = exp_q.pop_front();
            chk("fate_drop", 32'(dropped), 32'(e.drop));
            chk("word", 32'(bus.dado), 32'(e.data));
            chk("send_low_after_end", 32'(bus.send), 32'd0);
            if (!dropped) model_cnt = (model_cnt + 1) % (1 << CNT_W);
            chk("sent_count", 32'(bus.sent_count), 32'(model_cnt));
        end
        attempt = 0;
    endtask

    // Monitor plus peripheral responder; s_* hold what the DUT samples on the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            attempt = 0; hi_cnt = 0; lo_cnt = 0;
            s_send = 1'b0; s_ack = 1'b0; s_err = 1'b0;
            resp_ack = 1'b0;
        end else begin
            if (bus.send && exp_q.size() > 0) chk("dado_in_req", 32'(bus.dado), 32'(exp_q[0].data));
            if (bus.send) begin
                if (!s_send) begin
                    if (attempt > 0) gap_q.push_back(lo_cnt);
                    attempt++;
                    hi_cnt = 0;
                end
                hi_cnt++;
            end else begin
                if (s_send) begin
                    run_q.push_back(hi_cnt);
                    lo_cnt = 0;
                end
                lo_cnt++;
            end
            if (s_err) chk("err_pulse_width", 32'(bus.timeout_err), 32'd0);
            if (s_send && s_ack) word_event(1'b0);
            else if (bus.timeout_err) word_event(1'b1);
            resp_ack = bus.send && (attempt >= ack_attempt) && (hi_cnt > ack_delay);
            s_send = bus.send;
            s_ack  = manual ? man_ack : resp_ack;
            s_err  = bus.timeout_err;
        end
    end

    task automatic push(input logic [DATA_W-1:0] d, input bit drop);
        @(posedge clk); #1;
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        exp_q.push_back('{d, drop});
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic burst(input logic [DATA_W-1:0] base, input int n);
        @(posedge clk); #1;
        for (int k = 1; k <= n; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = base + DATA_W'(k);
            if (k <= DEPTH) exp_q.push_back('{base + DATA_W'(k), 1'b0});
            @(posedge clk); #1;
            chk("full_during_fill", 32'(bus.full), 32'(k >= DEPTH));
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d words outstanding after %0d cycles, expected 0", exp_q.size(), n);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_send(input int budget);
        int n = 0;
        while (!bus.send && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("send_seen", 32'(bus.send), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'hA5A5, 1, 2,  1'b0, 1};
        vecs[1] = '{16'h1234, 1, 0,  1'b0, 1};
        vecs[2] = '{16'hBEEF, 2, 0,  1'b0, 2};
        vecs[3] = '{16'h0F0F, 3, 5,  1'b0, 3};
        vecs[4] = '{16'hDEAD, NEVER, 0, 1'b1, 3};
        vecs[5] = '{16'hFFFF, 1, 14, 1'b0, 1};
        vecs[6] = '{16'h5555, 1, 15, 1'b1, 3};

        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        #12;
        chk("rst_send", 32'(bus.send), 32'd0);
        chk("rst_dado", 32'(bus.dado), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_count", 32'(bus.sent_count), 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            ack_attempt = vecs[i].attempt;
            ack_delay = vecs[i].delay;
            run_q.delete();
            gap_q.delete();
            push(vecs[i].data, vecs[i].drop);
            @(negedge clk); chk("send_before_req", 32'(bus.send), 32'd0);
            @(negedge clk); chk("send_two_edges", 32'(bus.send), 32'd1);
            wait_drain(200);
            chk("busy_idle", 32'(bus.busy), 32'd0);
            chk("windows", 32'(run_q.size()), 32'(vecs[i].windows));
            for (int w = 0; w < run_q.size() && w < vecs[i].windows; w++)
                chk("window_len", 32'(run_q[w]),
                    32'((w == vecs[i].windows - 1 && !vecs[i].drop) ? vecs[i].delay + 1 : TIMEOUT));
            chk("gaps", 32'(gap_q.size()), 32'(vecs[i].windows - 1));
            foreach (gap_q[g]) chk("gap_len", 32'(gap_q[g]), 32'd1);
        end

        // Fill past capacity with the peripheral silent, then let it ack immediately.
        ack_attempt = NEVER; ack_delay = 0;
        burst(16'h0000, 5);
        ack_attempt = 1;
        wait_drain(200);
        chk("busy_after_fill", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a request with a full queue.
        ack_attempt = NEVER;
        burst(16'h0100, 4);
        wait_send(20);
        @(negedge clk); #2;
        chk("full_before_rst", 32'(bus.full), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_send", 32'(bus.send), 32'd0);
        chk("rst_mid_full", 32'(bus.full), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("count_after_rst", 32'(bus.sent_count), 32'd0);
        chk("idle_after_rst", 32'(bus.busy), 32'd0);

        // Push and pop on the same edge at 3 entries, then deliver 5 words to wrap the counter.
        burst(16'h0200, 3);
        wait_send(20);
        manual = 1'b1; man_ack = 1'b0;
        @(posedge clk); #1;
        man_ack = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 16'h0204;
        exp_q.push_back('{16'h0204, 1'b0});
        @(posedge clk); #1;
        man_ack = 1'b0; bus.wr_en = 1'b0;
        chk("full_after_pushpop", 32'(bus.full), 32'd0);
        push(16'h0205, 1'b0);
        chk("full_after_extra", 32'(bus.full), 32'd1);
        manual = 1'b0; ack_attempt = 1; ack_delay = 0;
        wait_drain(200);
        chk("wrap_count", 32'(bus.sent_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
